// File: rtl/button_event_arbiter_if.sv
// Event channel from the button arbiter to the game-logic FSM.
// master = arbiter (producer), slave = consumer.
interface button_event_arbiter_if #(
    parameter int N_BTN = 4
);
    localparam int ID_W = $clog2(N_BTN);

    logic            ev_valid;
    logic            ev_ready;
    logic [ID_W-1:0] ev_id;
    logic            ev_long;

    modport master (
        output ev_valid,
        output ev_id,
        output ev_long,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_id,
        input  ev_long,
        output ev_ready
    );
endinterface

// File: rtl/button_event_arbiter.sv
// Short/long press classifier with one pending slot per button and a round-robin
// valid/ready event channel. Optional auto-repeat: define BTN_AUTO_REPEAT_EN.
//
// state     | meaning
// S_IDLE    | button released, waiting for a rising level
// S_HELD    | pressed, hold counter running toward LONG_CYCLES
// S_LONG_DONE | long event already posted, waiting for release
module button_event_arbiter #(
    parameter int N_BTN         = 4,
    parameter int LONG_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 12500000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_BTN-1:0]       btn_level,
    button_event_arbiter_if.master ev,
    output logic [N_BTN-1:0]       btn_busy,
    output logic                   overflow
);
    localparam int ID_W  = $clog2(N_BTN);
    localparam int CNT_W = $clog2(LONG_CYCLES + 1);
    localparam logic [CNT_W-1:0] LONG_C = CNT_W'(LONG_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HELD,
        S_LONG_DONE
    } btn_state_t;

    btn_state_t       state_q   [N_BTN];
    btn_state_t       state_nxt [N_BTN];
    logic [CNT_W-1:0] cnt_q     [N_BTN];
    logic [CNT_W-1:0] cnt_nxt   [N_BTN];

`ifdef BTN_AUTO_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [REP_W-1:0] REP_C = REP_W'(REPEAT_CYCLES);
    logic [REP_W-1:0] rep_q   [N_BTN];
    logic [REP_W-1:0] rep_nxt [N_BTN];
`endif

    logic [N_BTN-1:0] prev_q;
    logic [N_BTN-1:0] post;
    logic [N_BTN-1:0] post_long;
    logic [N_BTN-1:0] pend_q,  pend_nxt;
    logic [N_BTN-1:0] plong_q, plong_nxt;
    logic [N_BTN-1:0] busy_nxt;
    logic             ovf_set;

    logic            valid_q;
    logic [ID_W-1:0] id_q;
    logic            long_q;
    logic [ID_W-1:0] rr_q;
    logic            grant_any;
    logic [ID_W-1:0] grant_idx;

    function automatic logic [ID_W-1:0] rr_pick(input logic [N_BTN-1:0] p,
                                                 input logic [ID_W-1:0]  rr);
        logic [ID_W-1:0] pick;
        logic            found;
        int              j;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < N_BTN; k++) begin
            j = int'(rr) + k;
            if (j >= N_BTN) j = j - N_BTN;
            if (!found && p[ID_W'(j)]) begin
                found = 1'b1;
                pick  = ID_W'(j);
            end
        end
        return pick;
    endfunction

    // Per-button press classification.
    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            state_nxt[i] = state_q[i];
            cnt_nxt[i]   = cnt_q[i];
            post[i]      = 1'b0;
            post_long[i] = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
            rep_nxt[i]   = rep_q[i];
`endif
            case (state_q[i])
                S_IDLE: begin
                    if (btn_level[i] && !prev_q[i]) begin
                        state_nxt[i] = S_HELD;
                        cnt_nxt[i]   = CNT_W'(1);
                    end
                end
                S_HELD: begin
                    if (!btn_level[i]) begin
                        post[i]      = 1'b1;
                        state_nxt[i] = S_IDLE;
                        cnt_nxt[i]   = '0;
                    end else if (cnt_q[i] >= LONG_C - CNT_W'(1)) begin
                        // this cycle is the LONG_CYCLES-th held cycle
                        cnt_nxt[i]   = LONG_C;
                        post[i]      = 1'b1;
                        post_long[i] = 1'b1;
                        state_nxt[i] = S_LONG_DONE;
`ifdef BTN_AUTO_REPEAT_EN
                        rep_nxt[i]   = REP_W'(1);
`endif
                    end else begin
                        cnt_nxt[i]   = cnt_q[i] + CNT_W'(1);
                    end
                end
                S_LONG_DONE: begin
                    if (!btn_level[i]) begin
                        state_nxt[i] = S_IDLE;
                        cnt_nxt[i]   = '0;
`ifdef BTN_AUTO_REPEAT_EN
                    end else if (rep_q[i] == REP_C) begin
                        post[i]      = 1'b1;
                        post_long[i] = 1'b1;
                        rep_nxt[i]   = REP_W'(1);
                    end else begin
                        rep_nxt[i]   = rep_q[i] + REP_W'(1);
`endif
                    end
                end
                default: begin
                    state_nxt[i] = S_IDLE;
                    cnt_nxt[i]   = '0;
                end
            endcase
        end
    end

    // Arbitration and pending-slot update.
    always_comb begin
        grant_any = !valid_q && (|pend_q);
        grant_idx = rr_pick(pend_q, rr_q);
        pend_nxt  = pend_q;
        plong_nxt = plong_q;
        ovf_set   = 1'b0;
        busy_nxt  = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (grant_any && (grant_idx == ID_W'(i))) begin
                pend_nxt[i] = 1'b0;
            end
            if (post[i]) begin
                // a slot being granted this cycle can take the new event
                if (!pend_q[i] || (grant_any && (grant_idx == ID_W'(i)))) begin
                    pend_nxt[i]  = 1'b1;
                    plong_nxt[i] = post_long[i];
                end else begin
                    ovf_set = 1'b1;
                end
            end
            busy_nxt[i] = (state_nxt[i] != S_IDLE) | pend_nxt[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= S_IDLE;
                cnt_q[i]   <= '0;
`ifdef BTN_AUTO_REPEAT_EN
                rep_q[i]   <= '0;
`endif
            end
            prev_q   <= '0;
            pend_q   <= '0;
            plong_q  <= '0;
            btn_busy <= '0;
            overflow <= 1'b0;
            valid_q  <= 1'b0;
            id_q     <= '0;
            long_q   <= 1'b0;
            rr_q     <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= state_nxt[i];
                cnt_q[i]   <= cnt_nxt[i];
`ifdef BTN_AUTO_REPEAT_EN
                rep_q[i]   <= rep_nxt[i];
`endif
            end
            prev_q   <= btn_level;
            pend_q   <= pend_nxt;
            plong_q  <= plong_nxt;
            btn_busy <= busy_nxt;
            overflow <= overflow | ovf_set;
            if (valid_q) begin
                if (ev.ev_ready) valid_q <= 1'b0;
            end else if (grant_any) begin
                valid_q <= 1'b1;
                id_q    <= grant_idx;
                long_q  <= plong_q[grant_idx];
                rr_q    <= (grant_idx == ID_W'(N_BTN - 1)) ? '0 : grant_idx + ID_W'(1);
            end
        end
    end

    assign ev.ev_valid = valid_q;
    assign ev.ev_id    = id_q;
    assign ev.ev_long  = long_q;
endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter with LONG_CYCLES=8, REPEAT_CYCLES=4, N_BTN=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_button_event_arbiter;
    localparam int N  = 4;
    localparam int LC = 8;
    localparam int RC = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] btn_level = 4'b1111;
    logic [3:0] btn_busy;
    logic       overflow;
    int         checks = 0;
    int         errors = 0;

    button_event_arbiter_if #(.N_BTN(N)) ev_if();

    button_event_arbiter #(
        .N_BTN(N),
        .LONG_CYCLES(LC),
        .REPEAT_CYCLES(RC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_level(btn_level),
        .ev(ev_if),
        .btn_busy(btn_busy),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_ev(input string tag, input logic v, input int id, input logic lg);
        chk({tag, "_valid"}, 32'(ev_if.ev_valid), 32'(v));
        if (v) begin
            chk({tag, "_id"},   32'(ev_if.ev_id),   32'(id));
            chk({tag, "_long"}, 32'(ev_if.ev_long), 32'(lg));
        end
    endtask

    initial begin
        ev_if.ev_ready = 1'b1;

        // reset held with all buttons pressed
        cyc(3);
        chk("rst_valid", 32'(ev_if.ev_valid), 0);
        chk("rst_id",    32'(ev_if.ev_id),    0);
        chk("rst_long",  32'(ev_if.ev_long),  0);
        chk("rst_busy",  32'(btn_busy),       0);
        chk("rst_ovf",   32'(overflow),       0);
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cyc(1);
            chk("held_valid", 32'(ev_if.ev_valid), 0);
            chk("held_busy",  32'(btn_busy), 32'hF);
        end
        for (int k = 9; k <= 16; k++) begin
            cyc(1);
            chk_ev("all_long", (k % 2) == 1, (k - 9) / 2, 1'b1);
        end
        btn_level = 4'b0000;
        cyc(1);
        chk("all_rel_busy", 32'(btn_busy), 0);
        chk_ev("all_rel", 1'b0, 0, 1'b0);
        cyc(1);
        chk_ev("all_rel2", 1'b0, 0, 1'b0);

        // round robin with stall: buttons 0 and 3 together
        ev_if.ev_ready = 1'b0;
        btn_level = 4'b1001;
        cyc(2);
        btn_level = 4'b0000;
        cyc(1);
        chk_ev("rr_post", 1'b0, 0, 1'b0);
        chk("rr_post_busy", 32'(btn_busy), 32'h9);
        cyc(1);
        chk_ev("rr_g0", 1'b1, 0, 1'b0);
        chk("rr_g0_busy", 32'(btn_busy), 32'h8);
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            chk_ev("rr_stall", 1'b1, 0, 1'b0);
        end
        ev_if.ev_ready = 1'b1;
        cyc(1);
        chk_ev("rr_accept", 1'b0, 0, 1'b0);
        cyc(1);
        chk_ev("rr_g3", 1'b1, 3, 1'b0);
        cyc(1);
        chk_ev("rr_done", 1'b0, 0, 1'b0);

        // short press on button 2
        btn_level = 4'b0100;
        cyc(5);
        btn_level = 4'b0000;
        cyc(1);
        chk_ev("short_post", 1'b0, 0, 1'b0);
        chk("short_post_busy", 32'(btn_busy), 32'h4);
        cyc(1);
        chk_ev("short_ev", 1'b1, 2, 1'b0);
        chk("short_ev_busy", 32'(btn_busy), 0);
        cyc(1);
        chk_ev("short_done", 1'b0, 0, 1'b0);

        // long press on button 1, 20 cycles
        btn_level = 4'b0010;
        for (int k = 1; k <= 20; k++) begin
            cyc(1);
            chk_ev("long_hold", k == 9, 1, 1'b1);
        end
        btn_level = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            cyc(1);
            chk_ev("long_rel", 1'b0, 0, 1'b0);
        end
        chk("long_rel_busy", 32'(btn_busy), 0);

        // exactly LONG_CYCLES held -> long only
        btn_level = 4'b0001;
        for (int k = 1; k <= 8; k++) begin
            cyc(1);
            chk_ev("ex8_hold", 1'b0, 0, 1'b0);
        end
        btn_level = 4'b0000;
        cyc(1);
        chk_ev("ex8_ev", 1'b1, 0, 1'b1);
        cyc(1);
        chk_ev("ex8_after", 1'b0, 0, 1'b0);
        cyc(1);
        chk_ev("ex8_after2", 1'b0, 0, 1'b0);

        // LONG_CYCLES-1 held -> short
        btn_level = 4'b0001;
        cyc(7);
        btn_level = 4'b0000;
        cyc(1);
        chk_ev("ex7_post", 1'b0, 0, 1'b0);
        cyc(1);
        chk_ev("ex7_ev", 1'b1, 0, 1'b0);
        cyc(1);
        chk_ev("ex7_done", 1'b0, 0, 1'b0);

        // overflow: button 0 twice while button 1 event is unaccepted
        ev_if.ev_ready = 1'b0;
        btn_level = 4'b0010;
        cyc(2);
        btn_level = 4'b0000;
        cyc(2);
        chk_ev("ovf_b1", 1'b1, 1, 1'b0);
        chk("ovf_init", 32'(overflow), 0);
        btn_level = 4'b0001;
        cyc(2);
        btn_level = 4'b0000;
        cyc(1);
        chk("ovf_first", 32'(overflow), 0);
        chk("ovf_first_busy", 32'(btn_busy), 32'h1);
        btn_level = 4'b0001;
        cyc(2);
        btn_level = 4'b0000;
        cyc(1);
        chk("ovf_second", 32'(overflow), 1);
        chk_ev("ovf_hold", 1'b1, 1, 1'b0);
        ev_if.ev_ready = 1'b1;
        cyc(1);
        chk_ev("ovf_acc", 1'b0, 0, 1'b0);
        cyc(1);
        chk_ev("ovf_b0", 1'b1, 0, 1'b0);
        cyc(1);
        chk_ev("ovf_gap", 1'b0, 0, 1'b0);
        cyc(1);
        chk_ev("ovf_nodup", 1'b0, 0, 1'b0);
        chk("ovf_sticky", 32'(overflow), 1);

        // reset in the middle of a stalled handshake
        ev_if.ev_ready = 1'b0;
        btn_level = 4'b1100;
        cyc(2);
        btn_level = 4'b0000;
        cyc(2);
        chk_ev("mid_ev", 1'b1, 2, 1'b0);
        chk("mid_busy", 32'(btn_busy), 32'h8);
        reset = 1'b1;
        cyc(1);
        chk("mid_rst_valid", 32'(ev_if.ev_valid), 0);
        chk("mid_rst_id",    32'(ev_if.ev_id),    0);
        chk("mid_rst_ovf",   32'(overflow),       0);
        chk("mid_rst_busy",  32'(btn_busy),       0);
        reset = 1'b0;
        ev_if.ev_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            chk_ev("post_rst", 1'b0, 0, 1'b0);
            chk("post_rst_busy", 32'(btn_busy), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/button_event_arbiter.md
Name: button_event_arbiter

Overview:
- Sits downstream of one debounce instance per push-button.
- Takes each debounced level and classifies every press as short or long using a per-button hold counter.
- Queues one pending event per button.
- Shares a single event output channel between buttons using round-robin arbitration with a valid/ready handshake toward the game-logic FSM.

Parameters:
N_BTN, 4, number of debounced button inputs (2..8)
LONG_CYCLES, 25000000, held cycles at which a press becomes long (0.5 s at 50 MHz); must be >= 2
REPEAT_CYCLES, 12500000, auto-repeat period after a long press (used only with the optional feature)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
btn_level  input  N_BTN  debounced button levels (1 = pressed), one per debounce instance
ev_ready  input  1  consumer accepts the event on the current edge when ev_valid=1
ev_valid  output  1  event present on ev_id/ev_long
ev_id  output  clog2(N_BTN)  index of the button that produced the event
ev_long  output  1  1 = long press (or repeat), 0 = short press
btn_busy  output  N_BTN  per-button: currently held or event pending
overflow  output  1  sticky: an event was dropped because that button's pending slot was full

Behaviour:
- Reset: synchronous, active-high. Takes priority over all other activity, including mid-press and mid-handshake. On reset:
  - ev_valid=0, ev_id=0, ev_long=0, btn_busy=0, overflow=0.
  - All pending slots cleared, all counters cleared, RR pointer=0, prev_level register=0.
  - A button already held when reset deasserts counts as a new press at the first cycle with level=1 after reset.
- Per-button FSM, independent per button. States IDLE, HELD, LONG_DONE.
  - IDLE -> HELD on rise (level=1, prev=0). Counter loads 1.
  - HELD: counter increments each cycle while level=1, saturating at LONG_CYCLES.
    - Counter reaches LONG_CYCLES: post a long event; go to LONG_DONE.
    - Fall before that: post a short event; go to IDLE.
  - LONG_DONE: no event on release; go to IDLE on fall.
  - A press lasting exactly LONG_CYCLES cycles yields a long event only.
- Event posting: the pending slot (valid bit + long bit) is set on the clock edge after the detecting cycle.
  - If the slot is already valid and not being granted that same cycle: the new event is dropped, the slot is unchanged, and overflow is set.
- Arbitration:
  - When ev_valid=0 and any slot is pending, grant the first pending index at or after the RR pointer, wrapping modulo N_BTN.
  - On that edge: load ev_id/ev_long, set ev_valid=1, clear the granted slot, and set the RR pointer to granted+1 (mod N_BTN).
  - A slot granted and posted in the same cycle ends valid, holding the new event.
- Handshake:
  - While ev_valid=1 and ev_ready=0, ev_valid/ev_id/ev_long are held stable.
  - On ev_valid & ev_ready, ev_valid drops to 0 on the next edge. No grant happens in the accept cycle, so throughput is at most 1 event per 2 cycles.
  - ev_ready is ignored while ev_valid=0.
- Latency: the earliest ev_valid is 2 edges after the detecting cycle (post, then grant).
- btn_busy[i] = (state != IDLE) | pending[i]. Registered, same-cycle as state.
- Widths: counter width = clog2(LONG_CYCLES+1). REPEAT counter width = clog2(REPEAT_CYCLES+1).

Optional Feature:
- Macro BTN_AUTO_REPEAT_EN.
- When defined:
  - In LONG_DONE, a repeat counter starts at 1 and increments while the button is held.
  - Each time it reaches REPEAT_CYCLES, a further long event is posted (same overflow rules) and the counter reloads to 1.
  - Release goes to IDLE with no event.
- When undefined: LONG_DONE posts nothing until release, the repeat counter logic is absent, and REPEAT_CYCLES is unused.

Test Plan (LONG_CYCLES=8, REPEAT_CYCLES=4, N_BTN=4, ev_ready=1 unless stated):
- Reset check: hold reset 3 cycles with btn_level=4'b1111 -> all outputs 0. Release reset -> four presses detected, no events until release or count 8.
- Short press: btn_level[2]=1 for 5 cycles then 0 -> one event, ev_id=2, ev_long=0. ev_valid rises 2 edges after the fall cycle and lasts 1 cycle.
- Long press: btn_level[1]=1 for 20 cycles -> one event, ev_id=1, ev_long=1, posted when the count hits 8. No event on release.
  - With BTN_AUTO_REPEAT_EN: further ev_long=1 events every 4 held cycles (3 extra).
- Round-robin with stall: buttons 0 and 3 post short events in the same cycle, ev_ready=0 for 5 cycles -> ev_id=0 is held stable for 5 cycles. After accept, ev_valid=0 for one cycle, then ev_id=3.
- Overflow: ev_ready=0, button 0 does two short presses while its first event is still pending behind an unaccepted button-1 event -> second press dropped, overflow=1 stays set until reset.
- Reset mid-handshake: assert reset while ev_valid=1, ev_ready=0 -> next edge ev_valid=0, pending and overflow cleared, no stale event after reset.
